// File: rtl/l2_mem_responder_pkg.sv
// Shared types and default sizing for the L2 main-memory responder.
//   mem_state_type : transaction sequencer states
//   mem_grant_type : which request a transaction is serving
package l2_mem_responder_pkg;

    // Default sizing; the top-level parameters take these as defaults.
    localparam int unsigned DEFAULT_MEM_DEPTH   = 4096;
    localparam int unsigned DEFAULT_MEM_LATENCY = 4;

    // Counter width covers the full legal latency range 1..15.
    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        GAP
    } mem_state_type;

    typedef enum logic [1:0] {
        GRANT_INST,
        GRANT_DATA_RD,
        GRANT_DATA_WR
    } mem_grant_type;

endpackage : l2_mem_responder_pkg

// File: rtl/l2_mem_arbiter.sv
// Request-to-grant logic for the memory responder (combinational only).
//   inst_req        : instruction read pending
//   data_rd_req     : data read pending
//   data_wr_req     : data write pending
//   last_was_data   : round-robin pointer, 1 when the data channel won last
//   grant_valid_c   : some request is pending
//   grant_c         : request chosen for the next transaction
module l2_mem_arbiter
    import l2_mem_responder_pkg::*;
(
    input  logic          inst_req,
    input  logic          data_rd_req,
    input  logic          data_wr_req,
    input  logic          last_was_data,
    output logic          grant_valid_c,
    output mem_grant_type grant_c
);

    logic          data_pending;
    mem_grant_type data_grant;

    // Round-robin between channels; within the data channel a write beats a read.
    always_comb begin
        data_pending  = data_rd_req | data_wr_req;
        data_grant    = data_wr_req ? GRANT_DATA_WR : GRANT_DATA_RD;
        grant_valid_c = inst_req | data_pending;
        grant_c       = GRANT_INST;
        if (inst_req && data_pending) begin
            grant_c = last_was_data ? GRANT_INST : data_grant;
        end else if (data_pending) begin
            grant_c = data_grant;
        end
    end

endmodule : l2_mem_arbiter

// File: rtl/l2_mem_responder.sv
// Main-memory responder for the L2 memory-side request interface.
// Serves instruction-line reads and data reads/writes from a word array after
// a fixed latency, one transaction at a time, with one-cycle response pulses.
// The array has no reset and no built-in image load; environments preload it
// hierarchically or through the data write channel.
//   clk, rst        : clock, synchronous active-high reset
//   inst_read_req   : instruction read request, inst_addr its byte address
//   data_read_req   : data read request
//   data_write_req  : data write request, data_mem_write its data
//   data_addr       : byte address for the data channel
//   inst_mem_read   : instruction read data (held until next inst read)
//   data_mem_read   : data read data (held until next data read)
//   inst_res        : instruction channel completion pulse
//   data_res        : data channel completion pulse
module l2_mem_responder
    import l2_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned PC_LENGTH   = 32,
    parameter int unsigned INST_LENGTH = 32,
    parameter int unsigned MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_read_req,
    input  logic [PC_LENGTH-1:0]   inst_addr,
    input  logic                   data_read_req,
    input  logic                   data_write_req,
    input  logic [DATA_LENGTH-1:0] data_addr,
    input  logic [DATA_LENGTH-1:0] data_mem_write,
    output logic [INST_LENGTH-1:0] inst_mem_read,
    output logic [DATA_LENGTH-1:0] data_mem_read,
    output logic                   inst_res,
    output logic                   data_res
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic [DATA_LENGTH-1:0] mem_q [MEM_DEPTH];

    mem_state_type          state_q,        state_d;
    mem_grant_type          grant_q,        grant_d;
    logic [LAT_CNT_W-1:0]   cnt_q,          cnt_d;
    logic [AW-1:0]          addr_q,         addr_d;
    logic [DATA_LENGTH-1:0] wdata_q,        wdata_d;
    logic                   last_data_q,    last_data_d;
    logic                   inst_res_q,     inst_res_d;
    logic                   data_res_q,     data_res_d;
    logic [INST_LENGTH-1:0] inst_rdata_q,   inst_rdata_d;
    logic [DATA_LENGTH-1:0] data_rdata_q,   data_rdata_d;

    logic                   arb_valid_c;
    mem_grant_type          arb_grant_c;

    // Byte-offset bits and aliased upper bits play no part in the word index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[PC_LENGTH-1:AW+2], inst_addr[1:0],
                                data_addr[DATA_LENGTH-1:AW+2], data_addr[1:0]};

    l2_mem_arbiter u_arb (
        .inst_req      (inst_read_req),
        .data_rd_req   (data_read_req),
        .data_wr_req   (data_write_req),
        .last_was_data (last_data_q),
        .grant_valid_c (arb_valid_c),
        .grant_c       (arb_grant_c)
    );

    // Sequencer: IDLE grants, WAIT counts latency, RESP completes, GAP lets req drop.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_data_d  = last_data_q;
        inst_res_d   = 1'b0;
        data_res_d   = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    state_d     = WAIT;
                    grant_d     = arb_grant_c;
                    cnt_d       = LAT_CNT_W'(MEM_LATENCY - 1);
                    wdata_d     = data_mem_write;
                    last_data_d = (arb_grant_c != GRANT_INST);
                    addr_d      = (arb_grant_c == GRANT_INST) ? inst_addr[AW+1:2]
                                                              : data_addr[AW+1:2];
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Pulse and read data are registered so they appear during RESP.
                    state_d    = RESP;
                    inst_res_d = (grant_q == GRANT_INST);
                    data_res_d = (grant_q != GRANT_INST);
                    if (grant_q == GRANT_INST) begin
                        inst_rdata_d = INST_LENGTH'(mem_q[addr_q]);
                    end else if (grant_q == GRANT_DATA_RD) begin
                        data_rdata_d = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_INST;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_data_q  <= 1'b1;
            inst_res_q   <= 1'b0;
            data_res_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_data_q  <= last_data_d;
            inst_res_q   <= inst_res_d;
            data_res_q   <= data_res_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Write commits at the end of RESP, ahead of any later grant; reset abandons it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && grant_q == GRANT_DATA_WR) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign inst_mem_read = inst_rdata_q;
    assign data_mem_read = data_rdata_q;
    assign inst_res      = inst_res_q;
    assign data_res      = data_res_q;

endmodule : l2_mem_responder
